irq_sched: RTL and testbench

- Interrupt controller sitting between external event lines and the cpu core's single `inter` input.
- Latches rising edges on up to 8 request lines and masks them per source.
- Arbitrates one winner, drives `inter` and a jump vector, then tracks the acknowledge and end-of-interrupt handshake with the core.
- The core configures it through a small 8-bit register port mapped on its I/O space.

---
 rtl/irq_sched.sv | 161 ++++++++++++++++
 tb/tb_irq_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// Edge-latching, maskable interrupt controller with an IDLE/REQ/SERV handshake FSM.
// Optional rotating priority is enabled by defining IRQ_SCHED_ROT_PRIO_EN.
module irq_sched #(
  parameter int          N_SRC      = 4,
  parameter logic [7:0]  VEC_BASE   = 8'h10,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic             inta,
  input  logic             eoi,
  output logic             inter,
  output logic [7:0]       vec,
  output logic             in_serv
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] irq_q;
  logic             gie;
  logic [2:0]       id;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] id_onehot;
  logic [N_SRC-1:0] pend_clr;
  logic             mask_id;
  logic             ack;
  logic [2:0]       win;
  logic [7:0]       win_vec;
  logic             unused_wdata;

  assign req     = pend & mask;
  assign rise    = irq & ~irq_q;
  assign ack     = (state == REQ) && inta;
  assign mask_id = |(mask & id_onehot);
  assign win_vec = VEC_BASE + 8'(32'(win) * VEC_STRIDE);
  assign unused_wdata = ^wdata;

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_SRC; i++)
      id_onehot[i] = (id == 3'(i));
  end

  always_comb begin
    pend_clr = '0;
    if (wr_en && addr == 2'd1)
      pend_clr = wdata[N_SRC-1:0];
    if (ack)
      pend_clr = pend_clr | id_onehot;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = 8'(mask);
      2'd1:    rdata = 8'(pend);
      2'd2:    rdata = {5'b0, id};
      default: rdata = {7'b0, gie};
    endcase
  end

`ifdef IRQ_SCHED_ROT_PRIO_EN
  logic [2:0]         ptr;
  logic [2*N_SRC-1:0] req_dbl;
  logic [N_SRC-1:0]   req_rot;
  logic [2:0]         win_off;
  logic [3:0]         win_sum;

  // Rotate req so the pointer position becomes bit 0, pick the lowest bit, then rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N_SRC-1:0];
    win_off = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req_rot[i]) win_off = 3'(i);
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    if (win_sum >= 4'(N_SRC))
      win_sum = win_sum - 4'(N_SRC);
    win = win_sum[2:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (ack)
      ptr <= (id == 3'(N_SRC - 1)) ? 3'd0 : id + 3'd1;
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req[i]) win = 3'(i);
  end
`endif

  // A new edge always wins over a same-cycle clear, so no event is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= '1;
      pend  <= '0;
      mask  <= '0;
      gie   <= 1'b0;
    end else begin
      irq_q <= irq;
      pend  <= (pend & ~pend_clr) | rise;
      if (wr_en && addr == 2'd0)
        mask <= wdata[N_SRC-1:0];
      if (wr_en && addr == 2'd3)
        gie <= wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      inter   <= 1'b0;
      vec     <= VEC_BASE;
      id      <= '0;
      in_serv <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gie && |req) begin
            state <= REQ;
            inter <= 1'b1;
            id    <= win;
            vec   <= win_vec;
          end
        end
        REQ: begin
          if (inta) begin
            state   <= SERV;
            inter   <= 1'b0;
            in_serv <= 1'b1;
          end else if (!gie || !mask_id) begin
            state <= IDLE;
            inter <= 1'b0;
          end
        end
        SERV: begin
          if (eoi) begin
            state   <= IDLE;
            in_serv <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Directed self-checking bench for irq_sched; expected service order follows
// IRQ_SCHED_ROT_PRIO_EN when it is defined.
module tb_irq_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       wr_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       inta;
  logic       eoi;
  logic       inter;
  logic [7:0] vec;
  logic       in_serv;

  int checks = 0;
  int errors = 0;

  irq_sched #(.N_SRC(4), .VEC_BASE(8'h10), .VEC_STRIDE(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .inta    (inta),
    .eoi     (eoi),
    .inter   (inter),
    .vec     (vec),
    .in_serv (in_serv)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check_output(tag, rdata, exp);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_id;
    reset = 1'b0;
    irq   = '0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    inta  = 1'b0;
    eoi   = 1'b0;

    #12;
    check_output("rst_inter", {7'b0, inter}, 8'h00);
    check_output("rst_vec", vec, 8'h10);
    check_output("rst_in_serv", {7'b0, in_serv}, 8'h00);
    check_reg("rst_mask", 2'd0, 8'h00);
    check_reg("rst_pend", 2'd1, 8'h00);
    check_reg("rst_id", 2'd2, 8'h00);
    check_reg("rst_ctrl", 2'd3, 8'h00);
    reset = 1'b1;
    tick();

    // Single source 2, check one-edge latency from pend to inter
    wr_reg(2'd0, 8'h04);
    wr_reg(2'd3, 8'h01);
    check_reg("mask_rd", 2'd0, 8'h04);
    check_reg("ctrl_rd", 2'd3, 8'h01);
    irq = 4'b0100;
    tick();
    irq = '0;
    check_reg("pend_src2", 2'd1, 8'h04);
    check_output("inter_not_yet", {7'b0, inter}, 8'h00);
    tick();
    check_output("inter_src2", {7'b0, inter}, 8'h01);
    check_output("vec_src2", vec, 8'h18);
    check_reg("id_src2", 2'd2, 8'h02);

    pulse_inta();
    check_output("ack_inter", {7'b0, inter}, 8'h00);
    check_output("ack_in_serv", {7'b0, in_serv}, 8'h01);
    check_reg("ack_pend", 2'd1, 8'h00);
    pulse_eoi();
    check_output("eoi_in_serv", {7'b0, in_serv}, 8'h00);
    check_output("eoi_inter", {7'b0, inter}, 8'h00);
    tick();
    check_output("idle_inter", {7'b0, inter}, 8'h00);

    // Sources 1 and 3 together: 1 first, then 3
    wr_reg(2'd0, 8'h0F);
    irq = 4'b1010;
    tick();
    irq = '0;
    tick();
    check_output("pair_inter", {7'b0, inter}, 8'h01);
    check_output("pair_vec1", vec, 8'h14);
    pulse_inta();
    check_reg("pair_pend", 2'd1, 8'h08);
    pulse_eoi();
    check_output("pair_gap", {7'b0, inter}, 8'h00);
    tick();
    check_output("pair_inter2", {7'b0, inter}, 8'h01);
    check_output("pair_vec3", vec, 8'h1C);
    check_reg("pair_id3", 2'd2, 8'h03);
    pulse_inta();
    pulse_eoi();

    // Pending latches while masked; unmasking raises inter a cycle later
    wr_reg(2'd0, 8'h00);
    irq = 4'b0001;
    tick();
    irq = '0;
    check_reg("masked_pend", 2'd1, 8'h01);
    tick();
    check_output("masked_inter", {7'b0, inter}, 8'h00);
    wr_reg(2'd0, 8'h01);
    check_output("unmask_delay", {7'b0, inter}, 8'h00);
    tick();
    check_output("unmask_inter", {7'b0, inter}, 8'h01);
    check_output("unmask_vec", vec, 8'h10);

    // Write-1-clear racing a new edge on the same bit
    wr_en = 1'b1;
    addr  = 2'd1;
    wdata = 8'h01;
    irq   = 4'b0001;
    tick();
    wr_en = 1'b0;
    irq   = '0;
    check_reg("w1c_race_pend", 2'd1, 8'h01);
    check_output("w1c_race_inter", {7'b0, inter}, 8'h01);

    // Withdraw by clearing GIE while in REQ
    wr_reg(2'd3, 8'h00);
    check_output("gie_off_delay", {7'b0, inter}, 8'h01);
    tick();
    check_output("withdraw_inter", {7'b0, inter}, 8'h00);
    check_reg("withdraw_pend", 2'd1, 8'h01);
    wr_reg(2'd1, 8'h01);
    check_reg("w1c_pend", 2'd1, 8'h00);

    // Ignored inta outside REQ
    pulse_inta();
    check_output("stray_inta", {7'b0, in_serv}, 8'h00);

    // Reset asserted mid-REQ, with irq held high through release
    wr_reg(2'd3, 8'h01);
    irq = 4'b0001;
    tick();
    irq = '0;
    tick();
    check_output("pre_rst_inter", {7'b0, inter}, 8'h01);
    irq   = 4'b0001;
    reset = 1'b0;
    #1;
    check_output("async_inter", {7'b0, inter}, 8'h00);
    check_output("async_vec", vec, 8'h10);
    check_reg("async_mask", 2'd0, 8'h00);
    check_reg("async_ctrl", 2'd3, 8'h00);
    reset = 1'b1;
    tick();
    tick();
    check_reg("held_line_pend", 2'd1, 8'h00);
    irq = '0;

    // Sources 0 and 1 kept pending: fixed gives 0,0,0,0; rotating gives 0,1,0,1
    wr_reg(2'd0, 8'h03);
    wr_reg(2'd3, 8'h01);
    irq = 4'b0011;
    tick();
    irq = '0;
    for (int r = 0; r < 4; r++) begin
`ifdef IRQ_SCHED_ROT_PRIO_EN
      exp_id = 3'(r % 2);
`else
      exp_id = 3'd0;
`endif
      tick();
      check_output($sformatf("order_inter_%0d", r), {7'b0, inter}, 8'h01);
      check_output($sformatf("order_vec_%0d", r), vec, 8'h10 + 8'({5'b0, exp_id} * 8'd4));
      check_reg($sformatf("order_id_%0d", r), 2'd2, {5'b0, exp_id});
      pulse_inta();
      check_output($sformatf("order_serv_%0d", r), {7'b0, in_serv}, 8'h01);
      irq = 4'b0011;
      tick();
      irq = '0;
      check_output($sformatf("nest_inter_%0d", r), {7'b0, inter}, 8'h00);
      pulse_eoi();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
